// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing and test-pattern source.
// Drives vs/hs/de plus an 8-bit pattern pixel, one pixel per clock.
module video_timing_gen #(
    parameter int HAC      = 1920,
    parameter int HBP      = 3,
    parameter int HFP      = 3,
    parameter int VAC      = 1080,
    parameter int VBP      = 3,
    parameter int VFP      = 3,
    parameter int CNT_SIZE = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [1:0] i_pat_sel,
    output logic       o_vs,
    output logic       o_hs,
    output logic       o_de,
    output logic [7:0] o_data,
    output logic [7:0] o_frame_cnt,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        RUN   = 3'b010,
        DRAIN = 3'b100
    } state_t;

    localparam logic [CNT_SIZE-1:0] H_LAST = CNT_SIZE'(HBP + HAC + HFP);
    localparam logic [CNT_SIZE-1:0] V_LAST = CNT_SIZE'(VBP + VAC + VFP);
    localparam logic [CNT_SIZE-1:0] H_ACT0 = CNT_SIZE'(HBP + 1);
    localparam logic [CNT_SIZE-1:0] H_ACT1 = CNT_SIZE'(HBP + HAC);
    localparam logic [CNT_SIZE-1:0] V_ACT0 = CNT_SIZE'(VBP + 1);
    localparam logic [CNT_SIZE-1:0] V_ACT1 = CNT_SIZE'(VBP + VAC);
    localparam logic [7:0]          X_OFF  = 8'(HBP + 1);
    localparam logic [7:0]          Y_OFF  = 8'(VBP + 1);

    state_t              state;
    state_t              state_nxt;
    logic [CNT_SIZE-1:0] h;
    logic [CNT_SIZE-1:0] v;
    logic [CNT_SIZE-1:0] h_nxt;
    logic [CNT_SIZE-1:0] v_nxt;
    logic [1:0]          pat;
    logic                running;
    logic                frame_end;
    logic                h_act;
    logic                v_act;
    logic                de_nxt;
    logic [7:0]          x8;
    logic [7:0]          y8;
    logic [7:0]          pix;

    assign running   = (state == RUN) || (state == DRAIN);
    assign frame_end = (h == H_LAST) && (v == V_LAST);
    assign h_act     = (h >= H_ACT0) && (h <= H_ACT1);
    assign v_act     = (v >= V_ACT0) && (v <= V_ACT1);
    assign de_nxt    = running && h_act && v_act;
    // only the low byte of each coordinate is ever used
    assign x8        = h[7:0] - X_OFF;
    assign y8        = v[7:0] - Y_OFF;

    // next-state: frames always finish before returning to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_en) state_nxt = RUN;
            end
            RUN: begin
                if (!i_en && frame_end) state_nxt = IDLE;
                else if (!i_en)         state_nxt = DRAIN;
            end
            DRAIN: begin
                if (frame_end)  state_nxt = IDLE;
                else if (i_en)  state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // raster counters advance only while a frame is in flight
    always_comb begin
        h_nxt = '0;
        v_nxt = '0;
        if (running) begin
            if (h == H_LAST) begin
                h_nxt = '0;
                v_nxt = (v == V_LAST) ? '0 : v + CNT_SIZE'(1);
            end else begin
                h_nxt = h + CNT_SIZE'(1);
                v_nxt = v;
            end
        end
    end

    // pattern pixel for the current counter position
    always_comb begin
        pix = 8'h00;
        case (pat)
            2'd0: pix = x8;
            2'd1: pix = y8;
            2'd2: pix = (x8[3] ^ y8[3]) ? 8'hFF : 8'h00;
            2'd3: pix = o_frame_cnt;
            default: pix = 8'h00;
        endcase
    end

    // state and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            h     <= '0;
            v     <= '0;
        end else begin
            state <= state_nxt;
            h     <= h_nxt;
            v     <= v_nxt;
        end
    end

    // pattern select is sampled once per frame at its first cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat <= 2'd0;
        end else if (running && (h == '0) && (v == '0)) begin
            pat <= i_pat_sel;
        end
    end

    // registered timing and pixel outputs, one cycle behind counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_vs   <= 1'b0;
            o_hs   <= 1'b0;
            o_de   <= 1'b0;
            o_data <= 8'h00;
            o_busy <= 1'b0;
        end else begin
            o_vs   <= running && (h == '0) && (v == '0);
            o_hs   <= running && (h == '0);
            o_de   <= de_nxt;
            o_data <= de_nxt ? pix : 8'h00;
            o_busy <= (state_nxt != IDLE);
        end
    end

    // completed-frame counter, wraps naturally at 8 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_frame_cnt <= 8'h00;
        end else if (running && frame_end) begin
            o_frame_cnt <= o_frame_cnt + 8'h01;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: scoreboard bench for video_timing_gen.
// Expected vs/hs/pixel events are queued by stimulus, popped by a monitor.
module tb_video_timing_gen;

    localparam int FR  = 165;
    localparam int BIG = 32'h7fffffff;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_en;
    logic [1:0] i_pat_sel;
    logic       o_vs;
    logic       o_hs;
    logic       o_de;
    logic [7:0] o_data;
    logic [7:0] o_frame_cnt;
    logic       o_busy;

    int cyc = 0;
    int total = 0;
    int passed = 0;
    int k;
    int t0;

    int vs_cq[$];
    int vs_nq[$];
    int hs_q[$];
    int px_cq[$];
    int px_vq[$];

    video_timing_gen #(
        .HAC(8), .HBP(3), .HFP(3),
        .VAC(4), .VBP(3), .VFP(3),
        .CNT_SIZE(12)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_en(i_en),
        .i_pat_sel(i_pat_sel),
        .o_vs(o_vs),
        .o_hs(o_hs),
        .o_de(o_de),
        .o_data(o_data),
        .o_frame_cnt(o_frame_cnt),
        .o_busy(o_busy)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                      nm, act, exp, cyc);
    endtask

    task automatic miss(input string nm);
        total++;
        $display("FAIL %s: unexpected output at cycle %0d, expected none",
                 nm, cyc);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    function automatic int pix_val(input int sel, input int x,
                                   input int y, input int f);
        case (sel)
            0: return x;
            1: return y;
            2: return (((x >> 3) ^ (y >> 3)) & 1) != 0 ? 255 : 0;
            default: return f % 256;
        endcase
    endfunction

    // t0: edge after which the counters sit at h=v=0 for this frame
    task automatic push_frame(input int t0f, input int f,
                              input int sel, input int cut);
        int c;
        if (t0f + 1 <= cut) begin
            vs_cq.push_back(t0f + 1);
            vs_nq.push_back(f % 256);
        end
        for (int l = 0; l < 11; l++) begin
            c = t0f + 1 + 15 * l;
            if (c <= cut) hs_q.push_back(c);
        end
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 8; x++) begin
                c = t0f + ((y + 4) * 15 + x + 4) + 1;
                if (c <= cut) begin
                    px_cq.push_back(c);
                    px_vq.push_back(pix_val(sel, x, y, f));
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (o_vs) begin
            if (vs_cq.size() == 0) miss("vs_extra");
            else begin
                chk("vs_cycle", cyc, vs_cq.pop_front());
                chk("vs_frame_cnt", int'(o_frame_cnt), vs_nq.pop_front());
            end
        end
        if (o_hs) begin
            if (hs_q.size() == 0) miss("hs_extra");
            else chk("hs_cycle", cyc, hs_q.pop_front());
        end
        if (o_de) begin
            if (px_cq.size() == 0) miss("de_extra");
            else begin
                chk("de_cycle", cyc, px_cq.pop_front());
                chk("de_data", int'(o_data), px_vq.pop_front());
            end
        end else begin
            chk("data_zero_when_no_de", int'(o_data), 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: cycle %0d reached, expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        i_en = 1'b0;
        i_pat_sel = 2'd0;
        wait_cyc(3);
        chk("reset_outs", int'({o_vs, o_hs, o_de, o_data, o_busy}), 0);
        chk("reset_frame_cnt", int'(o_frame_cnt), 0);
        rst = 1'b0;
        wait_cyc(8);
        chk("idle_busy", int'(o_busy), 0);
        chk("idle_outs", int'({o_vs, o_hs, o_de, o_data}), 0);

        // frames with mid-frame pattern changes, then drain to idle
        k = cyc + 1;
        push_frame(k,          0, 0, BIG);
        push_frame(k + FR,     1, 1, BIG);
        push_frame(k + 2 * FR, 2, 2, BIG);
        push_frame(k + 3 * FR, 3, 3, BIG);
        push_frame(k + 4 * FR, 4, 3, BIG);
        i_en = 1'b1;
        wait_cyc(k);
        chk("start_busy", int'(o_busy), 1);
        chk("start_no_vs_yet", int'(o_vs), 0);
        wait_cyc(k + 100);
        i_pat_sel = 2'd1;
        wait_cyc(k + FR);
        chk("frame_cnt_1", int'(o_frame_cnt), 1);
        wait_cyc(k + FR + 100);
        i_pat_sel = 2'd2;
        wait_cyc(k + 2 * FR);
        chk("frame_cnt_2", int'(o_frame_cnt), 2);
        wait_cyc(k + 2 * FR + 100);
        i_pat_sel = 2'd3;
        wait_cyc(k + 3 * FR);
        chk("frame_cnt_3", int'(o_frame_cnt), 3);
        wait_cyc(k + 4 * FR + 75);
        i_en = 1'b0;
        wait_cyc(k + 5 * FR - 1);
        chk("drain_busy_last", int'(o_busy), 1);
        wait_cyc(k + 5 * FR);
        chk("drain_busy_off", int'(o_busy), 0);
        wait_cyc(k + 5 * FR + 60);
        chk("post_drain_outs", int'({o_vs, o_hs, o_de, o_data, o_busy}), 0);
        chk("post_drain_px_left", px_cq.size(), 0);

        // reset while idle clears the frame counter
        #2;
        rst = 1'b1;
        #1;
        chk("rst_idle_frame_cnt", int'(o_frame_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        wait_cyc(cyc + 3);

        // drain then re-raise, next frame follows without a gap
        k = cyc + 1;
        i_pat_sel = 2'd0;
        t0 = k + FR;
        push_frame(k,  0, 0, BIG);
        push_frame(t0, 1, 0, t0 + 83);
        i_en = 1'b1;
        wait_cyc(k + 75);
        i_en = 1'b0;
        wait_cyc(k + 77);
        chk("drain_busy", int'(o_busy), 1);
        wait_cyc(k + 120);
        i_en = 1'b1;
        wait_cyc(t0 + 83);
        chk("pre_rst_de", int'(o_de), 1);

        // asynchronous reset in the middle of an active burst
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_outs", int'({o_vs, o_hs, o_de, o_data, o_busy}), 0);
        chk("rst_async_frame_cnt", int'(o_frame_cnt), 0);
        i_pat_sel = 2'd3;
        @(negedge clk);
        chk("rst_px_left", px_cq.size(), 0);
        rst = 1'b0;

        // restart and run past the 8-bit frame counter wrap
        k = cyc + 1;
        for (int f = 0; f <= 256; f++) push_frame(k + f * FR, f, 3, BIG);
        wait_cyc(k);
        chk("restart_busy", int'(o_busy), 1);
        wait_cyc(k + 255 * FR);
        chk("frame_cnt_255", int'(o_frame_cnt), 255);
        wait_cyc(k + 256 * FR);
        chk("frame_cnt_wrap", int'(o_frame_cnt), 0);
        wait_cyc(k + 256 * FR + 75);
        i_en = 1'b0;
        wait_cyc(k + 257 * FR);
        chk("final_busy_off", int'(o_busy), 0);
        wait_cyc(k + 257 * FR + 30);
        chk("final_vs_left", vs_cq.size(), 0);
        chk("final_hs_left", hs_q.size(), 0);
        chk("final_px_left", px_cq.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
